tff_updown_counter: RTL and testbench

Synchronous up/down modulo counter built on T-flip-flop toggle semantics. Each cycle it computes a per-bit toggle vector and applies it to a register bank, so it behaves like WIDTH T flip-flops fed by toggle logic. It sits directly downstream of the single-bit T flip-flop stage and drives its outputs to frequency-divider and event-count logic. Features: runtime modulus, parallel load, terminal-count flag and wrap pulse.

---
 rtl/tff_updown_counter.sv | 76 +++++++
 tb/tb_tff_updown_counter.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/tff_updown_counter.sv
// Up/down modulo counter (range 0..max_val) realised as a bank of T flip-flops:
// each cycle a toggle vector is derived from the desired next count and XORed into the register.
module tff_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             wrap
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             upTerminal;
  logic             downTerminal;

  assign upTerminal   = (count_q >= max_val);
  assign downTerminal = (count_q == '0);

  // Desired next count; a count above max_val (max_val lowered at runtime) is pulled back into range.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (reset) begin
      count_d = '0;
    end else if (load) begin
      count_d = (load_val <= max_val) ? load_val : '0;
    end else if (en) begin
      if (up) begin
        if (upTerminal) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (downTerminal) begin
          count_d = max_val;
          wrap_d  = 1'b1;
        end else if (count_q > max_val) begin
          count_d = max_val;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  assign t_vec = count_q ^ count_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_q ^ t_vec;
      wrap_q  <= wrap_d;
    end
  end

  assign q     = count_q;
  assign q_bar = ~count_q;
  assign tc    = en & ~load & ((up & upTerminal) | (~up & downTerminal));
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Scoreboard bench for tff_updown_counter: stimulus pushes hand-computed expectations,
// a monitor pops and compares them once per cycle on the falling edge.
module tb_tff_updown_counter;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] loadVal;
  logic [3:0] maxVal;
  logic [3:0] q;
  logic [3:0] qBar;
  logic [3:0] tVec;
  logic       tc;
  logic       wrap;

  typedef struct {
    logic [3:0] q;
    logic       wrap;
    logic       tc;
    logic [3:0] tVec;
    string      name;
  } expect_t;

  expect_t scoreboard[$];
  int      checkCount = 0;
  int      errorCount = 0;
  bit      stimDone   = 1'b0;

  tff_updown_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (loadVal),
    .max_val  (maxVal),
    .q        (q),
    .q_bar    (qBar),
    .t_vec    (tVec),
    .tc       (tc),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] required);
    checkCount++;
    if (actual !== required) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
    end
  endtask

  // After an edge, drive the inputs for the next edge and record what the DUT must show
  // this cycle: q/wrap from the previous edge, tc/t_vec from the inputs just applied.
  task automatic applyStimulus(input logic r, input logic l, input logic e, input logic u,
                               input logic [3:0] lv, input logic [3:0] mv,
                               input logic [3:0] expQ, input logic expWrap,
                               input logic expTc, input logic [3:0] expTVec, input string name);
    expect_t item;
    @(posedge clk);
    #1;
    reset   = r;
    load    = l;
    en      = e;
    up      = u;
    loadVal = lv;
    maxVal  = mv;
    item.q    = expQ;
    item.wrap = expWrap;
    item.tc   = expTc;
    item.tVec = expTVec;
    item.name = name;
    scoreboard.push_back(item);
  endtask

  always @(negedge clk) begin
    if (scoreboard.size() > 0) begin
      expect_t item;
      item = scoreboard.pop_front();
      checkOutput({item.name, ".q"},     q,                 item.q);
      checkOutput({item.name, ".q_bar"}, qBar,              ~item.q);
      checkOutput({item.name, ".wrap"},  {3'b000, wrap},    {3'b000, item.wrap});
      checkOutput({item.name, ".tc"},    {3'b000, tc},      {3'b000, item.tc});
      checkOutput({item.name, ".t_vec"}, tVec,              item.tVec);
    end
  end

  initial begin
    reset = 1'b1; load = 1'b0; en = 1'b0; up = 1'b0; loadVal = 4'd0; maxVal = 4'd9;
    repeat (2) @(posedge clk);

    //             r  l  e  u  lv     mv     q      w  tc tv
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd0,  0, 0, 4'h1, "resetState");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd1,  0, 0, 4'h3, "up1");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd2,  0, 0, 4'h1, "up2");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd3,  0, 0, 4'h7, "up3");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd4,  0, 0, 4'h1, "up4");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd5,  0, 0, 4'h3, "up5");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd6,  0, 0, 4'h1, "up6");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd7,  0, 0, 4'hF, "up7");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd8,  0, 0, 4'h1, "up8");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd9,  0, 1, 4'h9, "up9");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd0,  1, 0, 4'h1, "upWrap");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd9,  4'd1,  0, 0, 4'h3, "up1b");
    applyStimulus(0, 1, 0, 1, 4'd2,  4'd9,  4'd2,  0, 0, 4'h0, "load2");
    applyStimulus(0, 0, 1, 0, 4'd0,  4'd9,  4'd2,  0, 0, 4'h3, "down2");
    applyStimulus(0, 0, 1, 0, 4'd0,  4'd9,  4'd1,  0, 0, 4'h1, "down1");
    applyStimulus(0, 0, 1, 0, 4'd0,  4'd9,  4'd0,  0, 1, 4'h9, "down0");
    applyStimulus(0, 0, 1, 0, 4'd0,  4'd9,  4'd9,  1, 0, 4'h1, "downWrap");
    applyStimulus(0, 1, 1, 1, 4'd5,  4'd9,  4'd8,  0, 0, 4'hD, "loadOverEn");
    applyStimulus(0, 1, 0, 1, 4'd12, 4'd9,  4'd5,  0, 0, 4'h5, "loadClamp");
    applyStimulus(0, 1, 0, 1, 4'd8,  4'd9,  4'd0,  0, 0, 4'h8, "clampResult");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd3,  4'd8,  0, 1, 4'h8, "lowerMaxUp");
    applyStimulus(0, 1, 0, 1, 4'd8,  4'd9,  4'd0,  1, 0, 4'h8, "lowerMaxUpWrap");
    applyStimulus(0, 0, 1, 0, 4'd0,  4'd3,  4'd8,  0, 0, 4'hB, "lowerMaxDown");
    applyStimulus(0, 0, 0, 1, 4'd0,  4'd9,  4'd3,  0, 0, 4'h0, "hold1");
    applyStimulus(0, 0, 0, 1, 4'd0,  4'd9,  4'd3,  0, 0, 4'h0, "hold2");
    applyStimulus(0, 0, 0, 1, 4'd0,  4'd9,  4'd3,  0, 0, 4'h0, "hold3");
    applyStimulus(0, 1, 0, 1, 4'd7,  4'd9,  4'd3,  0, 0, 4'h4, "load7");
    applyStimulus(1, 1, 1, 1, 4'd5,  4'd9,  4'd7,  0, 0, 4'h7, "resetOverLoad");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd0,  4'd0,  0, 1, 4'h0, "maxZero1");
    applyStimulus(0, 0, 1, 1, 4'd0,  4'd0,  4'd0,  1, 1, 4'h0, "maxZero2");
    applyStimulus(0, 0, 1, 0, 4'd0,  4'd0,  4'd0,  1, 1, 4'h0, "maxZero3");
    applyStimulus(0, 0, 0, 1, 4'd0,  4'd0,  4'd0,  1, 0, 4'h0, "maxZeroStop");
    applyStimulus(0, 0, 0, 1, 4'd0,  4'd0,  4'd0,  0, 0, 4'h0, "final");

    repeat (3) @(posedge clk);
    stimDone = 1'b1;
    checkOutput("scoreboardDrained", 4'(scoreboard.size()), 4'd0);
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

  initial begin
    #100000;
    if (!stimDone) begin
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] timeout");
    end
  end

endmodule
